// File: rtl/axis_frame_arbiter_if.sv
// Bundled AXI-stream ports of the frame arbiter: S_COUNT packed sources,
// one merged output, and the grant status.
interface axis_frame_arbiter_if #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(S_COUNT)
);
    logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
    logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [S_COUNT-1:0]            s_axis_tvalid;
    logic [S_COUNT-1:0]            s_axis_tready;
    logic [S_COUNT-1:0]            s_axis_tlast;
    logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [ID_WIDTH-1:0]           m_axis_tid;
    logic [USER_WIDTH-1:0]         m_axis_tuser;

    logic                          grant_valid;
    logic [ID_WIDTH-1:0]           grant_index;

    // The arbiter's own view: it consumes the sources and drives the output.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
        output grant_valid, grant_index
    );

    // The surrounding system: drives the sources and sinks the output.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
        input  grant_valid, grant_index
    );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin AXI-stream arbiter: a grant is held from the
// first beat to the tlast beat, output goes through one register stage.
module axis_frame_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_frame_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_next;
    logic [ID_WIDTH-1:0]   grant_index_reg;
    logic [ID_WIDTH-1:0]   last_ptr;
    logic [ID_WIDTH-1:0]   winner;
    logic                  masked_found;
    logic                  any_req;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_last;
    logic                  sel_valid;

    logic                  out_ready;
    logic                  accept;
    logic [S_COUNT-1:0]    tready;

    logic                  m_valid_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic [KEEP_WIDTH-1:0] m_keep_reg;
    logic [USER_WIDTH-1:0] m_user_reg;
    logic                  m_last_reg;
    logic [ID_WIDTH-1:0]   m_id_reg;

    assign any_req   = |bus.s_axis_tvalid;
    assign out_ready = bus.m_axis_tready || !m_valid_reg;
    assign accept    = (state == GRANT) && sel_valid && out_ready;

    // Round robin: lowest requester above the last grant, else lowest overall.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        winner       = '0;
        masked_found = 1'b0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (bus.s_axis_tvalid[i] && (i > int'(last_ptr))) begin
                winner       = ID_WIDTH'(i);
                masked_found = 1'b1;
            end
        end
        if (!masked_found) begin
            for (int i = S_COUNT - 1; i >= 0; i--) begin
                if (bus.s_axis_tvalid[i]) winner = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (ID_WIDTH'(i) == grant_index_reg) begin
                sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user  = bus.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_last  = bus.s_axis_tlast[i];
                sel_valid = bus.s_axis_tvalid[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        tready     = '0;
        case (state)
            IDLE: begin
                if (any_req) state_next = GRANT;
            end
            GRANT: begin
                for (int i = 0; i < S_COUNT; i++) begin
                    if (ID_WIDTH'(i) == grant_index_reg) tready[i] = out_ready;
                end
                if (accept && sel_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            grant_index_reg <= '0;
            last_ptr        <= ID_WIDTH'(S_COUNT - 1);
            m_valid_reg     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) grant_index_reg <= winner;
            if (accept && sel_last)       last_ptr        <= grant_index_reg;
            if (out_ready)                m_valid_reg     <= accept;
        end
    end

    // NOTE: the payload registers carry no reset; m_valid_reg alone qualifies
    // them, which keeps the reset tree off the datapath.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_data_reg <= sel_data;
            m_keep_reg <= sel_keep;
            m_user_reg <= sel_user;
            m_last_reg <= sel_last;
            m_id_reg   <= grant_index_reg;
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.m_axis_tdata  = m_data_reg;
    assign bus.m_axis_tkeep  = m_keep_reg;
    assign bus.m_axis_tvalid = m_valid_reg;
    assign bus.m_axis_tlast  = m_last_reg;
    assign bus.m_axis_tid    = m_id_reg;
    assign bus.m_axis_tuser  = m_user_reg;
    assign bus.grant_valid   = (state == GRANT);
    assign bus.grant_index   = grant_index_reg;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: per-source beat queues drive the
// inputs, accepted output beats are captured and compared to hand values.
module tb_axis_frame_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int IW = 2;

    typedef struct {
        logic       m_ready;
        logic       gv;
        logic       mv;
        logic [7:0] data;
        logic       tr;
    } vec_t;

    typedef struct {
        logic [7:0]    data;
        logic [KW-1:0] keep;
        logic          last;
        logic [IW-1:0] tid;
        logic          user;
        int            cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    axis_frame_arbiter_if #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                            .USER_WIDTH(UW), .ID_WIDTH(IW)) bus ();

    axis_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                         .USER_WIDTH(UW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] src_q [S][$];   // {last, data}
    beat_t      cap_q [$];
    int         cycle   = 0;
    int         n_check = 0;
    int         n_fail  = 0;
    vec_t       vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drive();
        logic [8:0] b;
        for (int i = 0; i < S; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                bus.s_axis_tvalid[i]         = 1'b1;
                bus.s_axis_tdata[i*DW +: DW] = b[7:0];
                bus.s_axis_tlast[i]          = b[8];
                bus.s_axis_tuser[i]          = b[0];
            end else begin
                bus.s_axis_tvalid[i]         = 1'b0;
                bus.s_axis_tdata[i*DW +: DW] = '0;
                bus.s_axis_tlast[i]          = 1'b0;
                bus.s_axis_tuser[i]          = 1'b0;
            end
        end
        bus.s_axis_tkeep = '1;
    endtask

    // Handshakes are judged at the negedge, consequences applied after the posedge.
    task automatic step();
        logic [S-1:0] fire_s;
        logic         fire_m;
        beat_t        ob;
        @(negedge clk);
        fire_s  = bus.s_axis_tvalid & bus.s_axis_tready;
        fire_m  = bus.m_axis_tvalid && bus.m_axis_tready;
        ob.data = bus.m_axis_tdata;
        ob.keep = bus.m_axis_tkeep;
        ob.last = bus.m_axis_tlast;
        ob.tid  = bus.m_axis_tid;
        ob.user = bus.m_axis_tuser[0];
        @(posedge clk);
        cycle++;
        ob.cyc = cycle;
        #1;
        for (int i = 0; i < S; i++)
            if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (fire_m) cap_q.push_back(ob);
        drive();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_beats(input int n, input string name);
        int budget = 200;
        while (cap_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
        check({name, "_timeout"}, 32'(cap_q.size() < n), 0);
    endtask

    task automatic check_beat(input string name, input int k, input logic [7:0] data,
                              input logic last, input logic [IW-1:0] tid);
        check({name, "_present"}, 32'(k < cap_q.size()), 1);
        if (k < cap_q.size()) begin
            check({name, "_data"}, 32'(cap_q[k].data), 32'(data));
            check({name, "_last"}, 32'(cap_q[k].last), 32'(last));
            check({name, "_tid"},  32'(cap_q[k].tid),  32'(tid));
            check({name, "_user"}, 32'(cap_q[k].user), 32'(data[0]));
        end
    endtask

    initial begin
        int  budget;
        int  k;
        logic [7:0] d;

        // Single source, repeated 1-beat frames: one beat every two cycles.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h71, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h72, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h73, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        rst = 1'b1;
        bus.m_axis_tready = 1'b1;
        drive();
        idle(2);
        check("rst_m_valid",     32'(bus.m_axis_tvalid), 0);
        check("rst_grant_valid", 32'(bus.grant_valid),   0);
        check("rst_s_ready",     32'(bus.s_axis_tready), 0);
        check("rst_grant_index", 32'(bus.grant_index),   0);
        rst = 1'b0;
        idle(1);

        // All four sources with 3-beat frames: served 0,1,2,3 with 1-cycle gaps.
        for (int i = 0; i < S; i++)
            for (int j = 0; j < 3; j++)
                src_q[i].push_back({(j == 2) ? 1'b1 : 1'b0, 4'(i), 4'(j + 1)});
        drive();
        wait_beats(12, "t1");
        for (int b = 0; b < 12; b++) begin
            d = {4'(b / 3), 4'(b % 3 + 1)};
            check_beat("t1_beat", b, d, (b % 3) == 2, IW'(b / 3));
        end
        if (cap_q.size() >= 12) begin
            check("t1_keep", 32'(cap_q[0].keep), 1);
            for (int b = 1; b < 12; b++)
                check("t1_gap", 32'(cap_q[b].cyc - cap_q[b-1].cyc), (b % 3 == 0) ? 2 : 1);
        end
        idle(3);
        cap_q.delete();

        // Pointer = 2: source 3 wins over 2; source 0 queued later follows 2.
        src_q[2].push_back({1'b1, 8'h2A});
        drive();
        wait_beats(1, "t2a");
        check_beat("t2_setup", 0, 8'h2A, 1'b1, 2);
        idle(3);
        cap_q.delete();
        src_q[3].push_back({1'b0, 8'h3B});
        src_q[3].push_back({1'b1, 8'h3C});
        src_q[2].push_back({1'b1, 8'h2D});
        drive();
        budget = 50;
        while (!(bus.grant_valid && bus.grant_index == 2) && budget > 0) begin
            step();
            budget--;
        end
        check("t2_grant2_timeout", 32'(budget == 0), 0);
        src_q[0].push_back({1'b1, 8'hA5});
        drive();
        wait_beats(4, "t2");
        check_beat("t2_b0", 0, 8'h3B, 1'b0, 3);
        check_beat("t2_b1", 1, 8'h3C, 1'b1, 3);
        check_beat("t2_b2", 2, 8'h2D, 1'b1, 2);
        check_beat("t2_b3", 3, 8'hA5, 1'b1, 0);
        idle(3);
        cap_q.delete();

        // Granted source 1 stalls mid-frame; source 0 must wait.
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[0].push_back({1'b1, 8'h01});
        drive();
        budget = 50;
        while (src_q[1].size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        check("t3_drain_timeout", 32'(budget == 0), 0);
        for (int n = 0; n < 5; n++) begin
            step();
            check("t3_hold_gv",  32'(bus.grant_valid),      1);
            check("t3_hold_gi",  32'(bus.grant_index),      1);
            check("t3_hold_rdy", 32'(bus.s_axis_tready[0]), 0);
        end
        check("t3_hold_count", 32'(cap_q.size()), 2);
        src_q[1].push_back({1'b1, 8'h13});
        drive();
        wait_beats(4, "t3");
        check_beat("t3_b0", 0, 8'h11, 1'b0, 1);
        check_beat("t3_b1", 1, 8'h12, 1'b0, 1);
        check_beat("t3_b2", 2, 8'h13, 1'b1, 1);
        check_beat("t3_b3", 3, 8'h01, 1'b1, 0);
        idle(3);
        cap_q.delete();

        // Output back-pressure 1,0,0,1 within a 4-beat frame from source 2.
        for (int j = 0; j < 4; j++) src_q[2].push_back({(j == 3) ? 1'b1 : 1'b0, 8'h41 + 8'(j)});
        drive();
        budget = 50;
        while (!bus.m_axis_tvalid && budget > 0) begin
            step();
            budget--;
        end
        check("t4_valid_timeout", 32'(budget == 0), 0);
        check("t4_first_data", 32'(bus.m_axis_tdata), 32'h41);
        step();
        bus.m_axis_tready = 1'b0;
        #1;
        check("t4_stall_rdy0", 32'(bus.s_axis_tready[2]), 0);
        for (int n = 0; n < 2; n++) begin
            step();
            check("t4_stall_valid", 32'(bus.m_axis_tvalid),    1);
            check("t4_stall_data",  32'(bus.m_axis_tdata),     32'h42);
            check("t4_stall_last",  32'(bus.m_axis_tlast),     0);
            check("t4_stall_tid",   32'(bus.m_axis_tid),       2);
            check("t4_stall_rdy",   32'(bus.s_axis_tready[2]), 0);
        end
        bus.m_axis_tready = 1'b1;
        #1;
        check("t4_resume_rdy", 32'(bus.s_axis_tready[2]), 1);
        wait_beats(4, "t4");
        idle(4);
        check("t4_count", 32'(cap_q.size()), 4);
        for (int j = 0; j < 4; j++) check_beat("t4_beat", j, 8'h41 + 8'(j), j == 3, 2);
        cap_q.delete();

        // Reset during beat 2 of a source 3 frame; source 0 wins afterwards.
        for (int j = 0; j < 4; j++) src_q[3].push_back({(j == 3) ? 1'b1 : 1'b0, 8'h51 + 8'(j)});
        src_q[0].push_back({1'b1, 8'h61});
        drive();
        budget = 50;
        while (!(bus.m_axis_tvalid && bus.m_axis_tdata == 8'h52) && budget > 0) begin
            step();
            budget--;
        end
        check("t5_beat2_timeout", 32'(budget == 0), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_m_valid", 32'(bus.m_axis_tvalid), 0);
        check("t5_rst_gv",      32'(bus.grant_valid),   0);
        check("t5_rst_rdy",     32'(bus.s_axis_tready), 0);
        src_q[3].delete();
        cap_q.delete();
        drive();
        #1;
        step();
        check("t5_regrant_gv", 32'(bus.grant_valid), 1);
        check("t5_regrant_gi", 32'(bus.grant_index), 0);
        wait_beats(1, "t5");
        idle(4);
        check("t5_count", 32'(cap_q.size()), 1);
        check_beat("t5_b0", 0, 8'h61, 1'b1, 0);
        cap_q.delete();

        // Table-driven sequence of back-to-back 1-beat frames from source 1.
        for (int j = 0; j < 3; j++) src_q[1].push_back({1'b1, 8'h71 + 8'(j)});
        drive();
        #1;
        for (int v = 0; v < 8; v++) begin
            bus.m_axis_tready = vecs[v].m_ready;
            step();
            check($sformatf("t6_gv_%0d", v),  32'(bus.grant_valid),      32'(vecs[v].gv));
            check($sformatf("t6_mv_%0d", v),  32'(bus.m_axis_tvalid),    32'(vecs[v].mv));
            check($sformatf("t6_rdy_%0d", v), 32'(bus.s_axis_tready[1]), 32'(vecs[v].tr));
            if (vecs[v].mv) begin
                check($sformatf("t6_data_%0d", v), 32'(bus.m_axis_tdata), 32'(vecs[v].data));
                check($sformatf("t6_tid_%0d", v),  32'(bus.m_axis_tid),   1);
            end
        end
        k = cap_q.size();
        check("t6_count", 32'(k), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
